// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  localparam logic [7:0] LOADER_HDR = 8'hA5;

  // Payload words arrive least-significant byte first.
  localparam bit LANE_LSB_FIRST = 1'b1;

endpackage

// File: rtl/byte_packer.sv
// Collects four stream bytes into one 32-bit word; word_done marks the cycle
// whose accepted byte completes the word (word is valid alongside it).
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] shreg;
  logic [1:0]  lane;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shreg <= '0;
      lane  <= '0;
    end else if (byte_valid) begin
      lane  <= lane + 2'd1;
      shreg <= LANE_LSB_FIRST ? {byte_data, shreg[23:8]} : {shreg[15:0], byte_data};
    end
  end

  assign word_done = byte_valid && (lane == 2'd3);
  assign word      = LANE_LSB_FIRST ? {byte_data, shreg} : {shreg, byte_data};

endmodule

// File: rtl/insn_loader.sv
// Framed byte-stream loader for the RV32I instruction memory; releases the core
// only after a frame with a matching XOR checksum.
//
// state  | meaning
// IDLE   | hunting for header byte, discarding others
// LEN_LO | expecting word-count low byte
// LEN_HI | expecting word-count high byte, range-checks the count
// DATA   | receiving payload, writing each completed word
// CSUM   | expecting checksum byte
// DONE   | frame good, core released (terminal)
// ERR    | bad count or checksum (terminal)
module insn_loader
  import loader_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  loader_state_e state, next_state;

  logic [15:0] len;
  logic [15:0] len_full;
  logic [7:0]  csum;
  logic        accept;
  logic        len_bad;
  logic        last_word;
  logic [31:0] word;
  logic        word_done;

  assign accept    = s_valid && s_ready;
  assign len_full  = {s_data, len[7:0]};
  assign len_bad   = (len_full == 16'd0) || (int'(len_full) > MEM_WORDS);
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(len);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == ST_LEN_HI),
    .byte_valid (accept && (state == ST_DATA)),
    .byte_data  (s_data),
    .word       (word),
    .word_done  (word_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (accept && (s_data == LOADER_HDR)) next_state = ST_LEN_LO;
      ST_LEN_LO: if (accept) next_state = ST_LEN_HI;
      ST_LEN_HI: if (accept) next_state = len_bad ? ST_ERR : ST_DATA;
      ST_DATA:   if (word_done && last_word) next_state = ST_CSUM;
      ST_CSUM:   if (accept) next_state = (s_data == csum) ? ST_DONE : ST_ERR;
      ST_DONE:   next_state = ST_DONE;
      ST_ERR:    next_state = ST_ERR;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len          <= '0;
      csum         <= '0;
      words_loaded <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        unique case (state)
          ST_LEN_LO: len[7:0] <= s_data;
          ST_LEN_HI: begin
            len[15:8]    <= s_data;
            csum         <= '0;
            words_loaded <= '0;
          end
          ST_DATA:   csum <= csum ^ s_data;
          default:   ;
        endcase
      end
      // Words are committed as they complete, before the checksum is known.
      if (word_done) begin
        mem_we       <= 1'b1;
        mem_addr     <= words_loaded[ADDR_W-1:0];
        mem_wdata    <= word;
        words_loaded <= words_loaded + 1'b1;
      end
    end
  end

  assign s_ready  = (state != ST_DONE) && (state != ST_ERR);
  assign busy     = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                    (state == ST_DATA)   || (state == ST_CSUM);
  assign core_run = (state == ST_DONE);
  assign error    = (state == ST_ERR);

endmodule

// File: tb/tb_insn_loader.sv
// Directed bench for insn_loader: byte-position frame model checked every cycle,
// plus literal expectations on memory contents and key outputs.
module tb_insn_loader;

  localparam int MEM_WORDS = 1024;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_run;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  insn_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_run     (core_run),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Frame model: position of the next byte within the frame, plus outcome flags.
  int          m_pos = 0;
  int          m_n = 0;
  logic [7:0]  m_x = 8'h00;
  logic [31:0] m_acc = 32'h0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  int          m_wl = 0;
  bit          m_we = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_wdata = 32'h0;

  always @(posedge clk) begin
    m_we = 1'b0;
    if (reset) begin
      m_pos = 0; m_n = 0; m_x = 8'h00; m_acc = 32'h0;
      m_done = 1'b0; m_err = 1'b0; m_wl = 0;
      m_addr = 0; m_wdata = 32'h0;
    end else if (s_valid && !m_done && !m_err) begin
      if (m_pos == 0) begin
        if (s_data == 8'hA5) m_pos = 1;
      end else if (m_pos == 1) begin
        m_n = int'(s_data);
        m_pos = 2;
      end else if (m_pos == 2) begin
        m_n = m_n + 256 * int'(s_data);
        m_wl = 0;
        m_x = 8'h00;
        if (m_n == 0 || m_n > MEM_WORDS) m_err = 1'b1;
        else m_pos = 3;
      end else if (m_pos < 3 + 4 * m_n) begin
        int k;
        k = m_pos - 3;
        m_x = m_x ^ s_data;
        m_acc[8*(k%4) +: 8] = s_data;
        if (k % 4 == 3) begin
          m_we = 1'b1;
          m_addr = k / 4;
          m_wdata = m_acc;
          m_wl = k / 4 + 1;
        end
        m_pos++;
      end else begin
        if (s_data == m_x) m_done = 1'b1;
        else m_err = 1'b1;
      end
    end
  end

  // Instruction memory image built from the DUT's write port.
  logic [31:0] mem_img [MEM_WORDS];
  int          nwrites = 0;
  int          last_addr = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      check("s_ready", 32'(s_ready), 32'(!m_done && !m_err));
      check("busy", 32'(busy), 32'((m_pos > 0) && !m_done && !m_err));
      check("error", 32'(error), 32'(m_err));
      check("core_run", 32'(core_run), 32'(m_done));
      check("words_loaded", 32'(words_loaded), 32'(m_wl));
      check("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) begin
        check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("mem_wdata", mem_wdata, m_wdata);
      end
    end
    if (mem_we === 1'b1) begin
      mem_img[mem_addr] = mem_wdata;
      nwrites++;
      last_addr = int'(mem_addr);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int tries;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    tries = 0;
    while (!s_ready && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    if (!s_ready) begin
      bad++;
      total++;
      $display("FAIL send_byte actual=not_ready required=ready byte=%h", b);
    end
  endtask

  task automatic bubble();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_run(string name);
    int cyc;
    cyc = 0;
    while (core_run !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(core_run), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [7:0]  gbytes [8];
    logic [7:0]  x;
    logic [31:0] w;
    logic [31:0] last_w;

    gbytes = '{8'h93, 8'h80, 8'h20, 8'h03, 8'h13, 8'hB1, 8'h40, 8'h01};

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_core_run", 32'(core_run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;

    // Good frame; XOR of the eight payload bytes is D3.
    w0 = nwrites;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    foreach (gbytes[i]) send_byte(gbytes[i]);
    send_byte(8'hD3);
    check("good_run_before", 32'(core_run), 32'd0);
    bubble();
    check("good_run_next", 32'(core_run), 32'd1);
    check("good_ready_low", 32'(s_ready), 32'd0);
    check("good_mem0", mem_img[0], 32'h03208093);
    check("good_mem1", mem_img[1], 32'h0140B113);
    check("good_words", 32'(words_loaded), 32'd2);
    check("good_nwrites", 32'(nwrites - w0), 32'd2);
    @(negedge clk); s_valid = 1'b1; s_data = 8'hA5;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check("done_hold_run", 32'(core_run), 32'd1);
    check("done_hold_busy", 32'(busy), 32'd0);

    // Bad checksum.
    do_reset();
    w0 = nwrites;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    foreach (gbytes[i]) send_byte(gbytes[i]);
    send_byte(8'h06);
    bubble();
    repeat (2) @(negedge clk);
    check("badck_error", 32'(error), 32'd1);
    check("badck_run", 32'(core_run), 32'd0);
    check("badck_ready", 32'(s_ready), 32'd0);
    check("badck_nwrites", 32'(nwrites - w0), 32'd2);
    check("badck_mem1", mem_img[1], 32'h0140B113);

    // Zero count.
    do_reset();
    w0 = nwrites;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    bubble();
    repeat (2) @(negedge clk);
    check("n0_error", 32'(error), 32'd1);
    check("n0_nwrites", 32'(nwrites - w0), 32'd0);

    // Count 1025.
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
    bubble();
    repeat (2) @(negedge clk);
    check("n1025_error", 32'(error), 32'd1);
    check("n1025_ready", 32'(s_ready), 32'd0);

    // Leading garbage with bubbles; EF^BE^AD^DE = 22.
    do_reset();
    w0 = nwrites;
    begin
      logic [7:0] seq [10];
      seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      foreach (seq[i]) begin
        send_byte(seq[i]);
        bubble();
      end
    end
    wait_run("garb_run");
    check("garb_mem0", mem_img[0], 32'hDEADBEEF);
    check("garb_nwrites", 32'(nwrites - w0), 32'd1);
    check("garb_words", 32'(words_loaded), 32'd1);

    // Reset after six payload bytes, then a fresh one-word frame; 0D^0C^0B^0A = 00.
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    do_reset();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_words", 32'(words_loaded), 32'd0);
    check("abort_mem0_kept", mem_img[0], 32'h44332211);
    w0 = nwrites;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'h0C); send_byte(8'h0B); send_byte(8'h0A);
    send_byte(8'h00);
    bubble();
    wait_run("abort_run");
    check("abort_mem0_new", mem_img[0], 32'h0A0B0C0D);
    check("abort_words_new", 32'(words_loaded), 32'd1);
    check("abort_nwrites", 32'(nwrites - w0), 32'd1);

    // Full depth.
    do_reset();
    w0 = nwrites;
    x = 8'h00;
    last_w = 32'h0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
    for (int i = 0; i < MEM_WORDS; i++) begin
      w = 32'h9E3779B9 * 32'(i + 1);
      last_w = w;
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8]);
        x = x ^ w[8*j +: 8];
      end
    end
    check("full_run_before", 32'(core_run), 32'd0);
    send_byte(x);
    bubble();
    wait_run("full_run");
    check("full_last_addr", 32'(last_addr), 32'd1023);
    check("full_last_word", mem_img[1023], last_w);
    check("full_words", 32'(words_loaded), 32'd1024);
    check("full_nwrites", 32'(nwrites - w0), 32'd1024);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
